// File: rtl/adc128s_pkg.sv
// adc128s_pkg: shared types and helpers for the ADC128S reader and its benches.
//   state_t    - externally visible conversion state (debug output of the reader)
//   seq_t      - two-frame sequencer state inside the reader
//   chnl_t     - 3-bit ADC channel number
//   FRAME_BITS - SPI frame length in bits
//   build_cmd  - command word that addresses a channel
package adc128s_pkg;

  localparam int FRAME_BITS = 16;

  typedef logic [2:0] chnl_t;

  typedef enum logic [2:0] {
    IDLE,
    FRONT,
    SHIFT,
    BACK,
    GAP,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_F1,
    SEQ_GAP,
    SEQ_F2,
    SEQ_DONE
  } seq_t;

  // The channel address sits in bits [13:11]; every other bit is zero.
  function automatic logic [FRAME_BITS-1:0] build_cmd(input chnl_t ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/adc128s_spi_mstr16.sv
// spi_mstr16: single 16-bit SPI frame engine (clock divider, SCLK, SS_n,
// shift register). SCLK idles high, the slave shifts on falling SCLK and
// MISO is sampled on rising SCLK.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   start      - begin a frame (taken only while idle)
//   cmd        - word to transmit, loaded when SS_n falls
//   miso       - serial data from the slave (already clk-synchronous)
//   done       - one-clk pulse in the last clk of the frame
//   rx         - low 12 bits of the received word
//   ss_n, sclk, mosi - registered SPI outputs
//   state      - engine state (IDLE/FRONT/SHIFT/BACK)
//
// Handshake: start is a request that is honoured only when state==IDLE and
// ignored otherwise; done is a single-cycle completion strobe, and rx is
// valid from the done cycle until the next accepted start.
module spi_mstr16
  import adc128s_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] cmd,
  input  logic                  miso,
  output logic                  done,
  output logic [11:0]           rx,
  output logic                  ss_n,
  output logic                  sclk,
  output logic                  mosi,
  output state_t                state
);

  localparam int H  = SCLK_DIV / 2;
  localparam int CW = $clog2(SCLK_DIV);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t H_M1   = cnt_t'(H - 1);
  localparam cnt_t DIV_M1 = cnt_t'(SCLK_DIV - 1);

  state_t                state_nxt;
  cnt_t                  cnt;
  logic [4:0]            per;
  logic [FRAME_BITS-1:0] shft;
  logic                  miso_smpl;

  logic front_end, rise_pt, period_end, last_period, back_end;

  assign front_end   = (state == FRONT) && (cnt == H_M1);
  assign rise_pt     = (state == SHIFT) && (cnt == H_M1);
  assign period_end  = (state == SHIFT) && (cnt == DIV_M1);
  assign last_period = (per == 5'(FRAME_BITS - 1));
  assign back_end    = (state == BACK) && (cnt == H_M1);

  assign done = back_end;
  assign mosi = shft[FRAME_BITS-1];
  assign rx   = shft[11:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FRONT;
      FRONT:   if (front_end) state_nxt = SHIFT;
      SHIFT:   if (period_end && last_period) state_nxt = BACK;
      BACK:    if (back_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each SCLK period is low for H clks then high for H clks. The first fall
  // (leaving FRONT) only starts the clock; every later fall, plus the step
  // into BACK, shifts in the bit sampled on the preceding rise, giving
  // exactly FRAME_BITS shifts with MOSI stable across every rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      per       <= '0;
      shft      <= '0;
      miso_smpl <= 1'b0;
      ss_n      <= 1'b1;
      sclk      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ss_n <= 1'b0;
            shft <= cmd;
            cnt  <= '0;
            per  <= '0;
          end
        end
        FRONT: begin
          if (front_end) begin
            cnt  <= '0;
            sclk <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (rise_pt) begin
            sclk      <= 1'b1;
            miso_smpl <= miso;
          end
          if (period_end) begin
            cnt  <= '0;
            per  <= per + 5'd1;
            shft <= {shft[FRAME_BITS-2:0], miso_smpl};
            if (!last_period) sclk <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BACK: begin
          if (back_end) begin
            ss_n <= 1'b1;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adc128s_reader.sv
// adc128s_reader: runs the two SPI frames an ADC128S conversion needs. Frame 1
// addresses the channel; frame 2 re-sends the address and returns the result.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   strt       - start-conversion request (accepted only when idle)
//   chnnl      - channel to convert, captured when strt is accepted
//   res        - last 12-bit result, held until the next completion
//   cnv_cmplt  - one-clk pulse when res updates
//   busy       - high from strt acceptance through the cnv_cmplt cycle
//   SS_n, SCLK, MOSI - SPI outputs (registered), MISO - SPI input
//   state      - debug view of the conversion state
module adc128s_reader
  import adc128s_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt,
  input  logic [2:0]  chnnl,
  output logic [11:0] res,
  output logic        cnv_cmplt,
  output logic        busy,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output state_t      state
);

  localparam int H  = SCLK_DIV / 2;
  localparam int CW = $clog2(SCLK_DIV);
  typedef logic [CW-1:0] gcnt_t;
  // The engine drops SS_n in the clk it finishes, and the registered go
  // costs one more clk, so the gap counter runs H-2 steps to keep SS_n high
  // for exactly H clks between the frames.
  localparam gcnt_t GAP_LAST = gcnt_t'(H - 2);

  seq_t        seq, seq_nxt;
  chnl_t       chnnl_q;
  gcnt_t       gcnt;
  logic        go;
  logic        gap_last;
  logic        eng_done;
  logic [11:0] eng_rx;
  state_t      eng_state;

  assign gap_last  = (seq == SEQ_GAP) && (gcnt == GAP_LAST);
  assign busy      = (seq != SEQ_IDLE);
  assign cnv_cmplt = (seq == SEQ_DONE);

  spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk   (clk),
    .rst   (rst),
    .start (go),
    .cmd   (build_cmd(chnnl_q)),
    .miso  (MISO),
    .done  (eng_done),
    .rx    (eng_rx),
    .ss_n  (SS_n),
    .sclk  (SCLK),
    .mosi  (MOSI),
    .state (eng_state)
  );

  always_ff @(posedge clk) begin
    if (rst) seq <= SEQ_IDLE;
    else     seq <= seq_nxt;
  end

  always_comb begin
    seq_nxt = seq;
    case (seq)
      SEQ_IDLE: if (strt) seq_nxt = SEQ_F1;
      SEQ_F1:   if (eng_done) seq_nxt = SEQ_GAP;
      SEQ_GAP:  if (gap_last) seq_nxt = SEQ_F2;
      SEQ_F2:   if (eng_done) seq_nxt = SEQ_DONE;
      SEQ_DONE: seq_nxt = SEQ_IDLE;
      default:  seq_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chnnl_q <= '0;
      gcnt    <= '0;
      go      <= 1'b0;
      res     <= '0;
    end else begin
      go <= 1'b0;
      case (seq)
        SEQ_IDLE: begin
          if (strt) begin
            chnnl_q <= chnnl;
            go      <= 1'b1;
          end
        end
        SEQ_F1: gcnt <= '0;
        SEQ_GAP: begin
          if (gap_last) go <= 1'b1;
          else          gcnt <= gcnt + 1'b1;
        end
        // Frame 1 data is never looked at; only frame 2 lands in res.
        SEQ_F2: if (eng_done) res <= eng_rx;
        default: ;
      endcase
    end
  end

  // While a frame is pending (go registered, engine not yet started) the
  // conversion is already in its front porch, so report FRONT.
  always_comb begin
    state = IDLE;
    case (seq)
      SEQ_F1, SEQ_F2: state = (eng_state == IDLE) ? FRONT : eng_state;
      SEQ_GAP:        state = GAP;
      SEQ_DONE:       state = DONE;
      default:        state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc128s_reader.sv
module tb_adc128s_reader;
  import adc128s_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT, SCLK_DIV = 32 ----------------
  logic        strt, miso;
  logic [2:0]  chnnl;
  logic [11:0] res;
  logic        cnv_cmplt, busy, ss_n, sclk, mosi;
  state_t      state;

  adc128s_reader #(.SCLK_DIV(32)) dut (
    .clk(clk), .rst(rst), .strt(strt), .chnnl(chnnl), .res(res),
    .cnv_cmplt(cnv_cmplt), .busy(busy), .SS_n(ss_n), .SCLK(sclk),
    .MOSI(mosi), .MISO(miso), .state(state)
  );

  // ---------------- DUT, SCLK_DIV = 4 ----------------
  logic        strt4, miso4;
  logic [2:0]  chnnl4;
  logic [11:0] res4;
  logic        cmplt4, busy4, ss_n4, sclk4, mosi4;
  state_t      state4;

  adc128s_reader #(.SCLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .strt(strt4), .chnnl(chnnl4), .res(res4),
    .cnv_cmplt(cmplt4), .busy(busy4), .SS_n(ss_n4), .SCLK(sclk4),
    .MOSI(mosi4), .MISO(miso4), .state(state4)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- ADC responder + MOSI monitor (DIV 32) ----------------
  // The responder presents word bit 15 when SS_n falls and the next bit on
  // every SCLK fall after the first, so the master's 16 samples equal the word.
  logic [15:0] rsp_word[2];
  logic [15:0] rsp_sh;
  int          rsp_fr;
  bit          rsp_first;
  logic [15:0] mosi_sh;
  logic [15:0] mosi_w[2];
  int          rise_w[2];
  int          n_rises;

  always @(negedge ss_n) begin
    rsp_sh    = rsp_word[(rsp_fr > 0) ? 1 : 0];
    miso      = rsp_sh[15];
    rsp_first = 1'b1;
    mosi_sh   = '0;
    n_rises   = 0;
  end

  always @(negedge sclk) begin
    if (ss_n === 1'b0) begin
      if (rsp_first) rsp_first = 1'b0;
      else begin
        rsp_sh = {rsp_sh[14:0], 1'b0};
        miso   = rsp_sh[15];
      end
    end
  end

  always @(posedge sclk) begin
    if (ss_n === 1'b0) begin
      mosi_sh = {mosi_sh[14:0], mosi};
      n_rises++;
    end
  end

  always @(posedge ss_n) begin
    if (rsp_fr == 0) begin mosi_w[0] = mosi_sh; rise_w[0] = n_rises; end
    if (rsp_fr == 1) begin mosi_w[1] = mosi_sh; rise_w[1] = n_rises; end
    rsp_fr++;
  end

  // ---------------- ADC responder (DIV 4) ----------------
  logic [15:0] rsp4_word[2];
  logic [15:0] rsp4_sh;
  int          rsp4_fr;
  bit          rsp4_first;

  always @(negedge ss_n4) begin
    rsp4_sh    = rsp4_word[(rsp4_fr > 0) ? 1 : 0];
    miso4      = rsp4_sh[15];
    rsp4_first = 1'b1;
  end

  always @(negedge sclk4) begin
    if (ss_n4 === 1'b0) begin
      if (rsp4_first) rsp4_first = 1'b0;
      else begin
        rsp4_sh = {rsp4_sh[14:0], 1'b0};
        miso4   = rsp4_sh[15];
      end
    end
  end

  always @(posedge ss_n4) rsp4_fr++;

  // ---------------- driver: one conversion on the DIV 32 DUT ----------------
  // Labels n count posedges after the one that samples strt (edge 0); each
  // label is observed on the following negedge.
  int fall_at[2], rise_at[2];
  int n_fall, n_rise, n_cmplt, cmplt_at;

  task automatic do_conv(input logic [2:0] ch, input logic [15:0] w2,
                         input bit hammer, input int rst_at);
    logic prev_ss;
    rsp_word[0] = ~w2;        // frame 1 data must never reach res
    rsp_word[1] = w2;
    rsp_fr   = 0;
    n_fall   = 0;
    n_rise   = 0;
    n_cmplt  = 0;
    cmplt_at = -1;
    fall_at  = '{-1, -1};
    rise_at  = '{-1, -1};
    if (rst_at == 0) exp_q.push_back(w2[11:0]);
    @(negedge clk);
    strt    = 1'b1;
    chnnl   = ch;
    prev_ss = ss_n;
    for (int n = 0; n < 1400; n++) begin
      @(negedge clk);
      if (ss_n !== prev_ss) begin
        if (ss_n === 1'b0) begin
          if (n_fall < 2) fall_at[n_fall] = n;
          n_fall++;
        end else begin
          if (n_rise < 2) rise_at[n_rise] = n;
          n_rise++;
        end
      end
      prev_ss = ss_n;
      if (n == 550) check("gap_state", 32'(state), 32'(GAP));
      if (cnv_cmplt) begin
        n_cmplt++;
        if (cmplt_at < 0) cmplt_at = n;
        if (exp_q.size() > 0) check("res", 32'(res), 32'(exp_q.pop_front()));
      end
      if (rst_at > 0 && n == rst_at) check("pre_rst_state", 32'(state), 32'(SHIFT));
      if (rst_at > 0 && n == rst_at + 1) begin
        check("rst_ss_n", 32'(ss_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        rst = 1'b0;
        break;
      end
      if (cmplt_at >= 0 && n == cmplt_at + 3) break;
      // stimulus for edge n+1
      strt = 1'b0;
      if (hammer && busy && cmplt_at < 0) begin
        strt  = 1'($urandom_range(0, 1));
        chnnl = 3'($urandom_range(0, 7));
      end
      if (cnv_cmplt) strt = 1'b1;   // lands in the DONE cycle: must be ignored
      if (rst_at > 0 && n == rst_at) rst = 1'b1;
    end
    strt = 1'b0;
  endtask

  task automatic check_conv(input logic [15:0] cmd_exp);
    check("f1_fall", 32'(fall_at[0]), 32'd1);
    check("f1_rise", 32'(rise_at[0]), 32'd545);
    check("f2_fall", 32'(fall_at[1]), 32'd561);
    check("f2_rise", 32'(rise_at[1]), 32'd1105);
    check("n_frames", 32'(n_fall), 32'd2);
    check("cmplt_at", 32'(cmplt_at), 32'd1105);
    check("n_cmplt", 32'(n_cmplt), 32'd1);
    check("mosi_f1", 32'(mosi_w[0]), 32'(cmd_exp));
    check("mosi_f2", 32'(mosi_w[1]), 32'(cmd_exp));
    check("rises_f1", 32'(rise_w[0]), 32'd16);
    check("rises_f2", 32'(rise_w[1]), 32'd16);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  // ---------------- driver: one conversion on the DIV 4 DUT ----------------
  task automatic do_conv4();
    int   last_tog, min_gap, max_gap, n_tog, c_at;
    logic prev_sclk, prev_ss;
    rsp4_word[0] = 16'hA5A5;
    rsp4_word[1] = 16'h5A5A;
    rsp4_fr  = 0;
    min_gap  = 1000;
    max_gap  = 0;
    n_tog    = 0;
    c_at     = -1;
    last_tog = 0;
    @(negedge clk);
    strt4     = 1'b1;
    chnnl4    = 3'd6;
    prev_sclk = sclk4;
    prev_ss   = ss_n4;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      strt4 = 1'b0;
      if (prev_ss === 1'b1 && ss_n4 === 1'b0) last_tog = n;
      if (ss_n4 === 1'b0 && sclk4 !== prev_sclk) begin
        n_tog++;
        if (n - last_tog < min_gap) min_gap = n - last_tog;
        if (n - last_tog > max_gap) max_gap = n - last_tog;
        last_tog = n;
      end
      prev_sclk = sclk4;
      prev_ss   = ss_n4;
      if (cmplt4 && c_at < 0) c_at = n;
      if (c_at >= 0 && n == c_at + 2) break;
    end
    check("div4_cmplt_at", 32'(c_at), 32'd139);
    check("div4_res", 32'(res4), 32'hA5A);
    check("div4_toggles", 32'(n_tog), 32'd64);
    check("div4_min_half", 32'(min_gap), 32'd2);
    check("div4_max_half", 32'(max_gap), 32'd2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cmplt_cnt;
    strt = 1'b0; chnnl = '0; miso = 1'b0;
    strt4 = 1'b0; chnnl4 = '0; miso4 = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ss_n", 32'(ss_n), 32'd1);
    check("reset_sclk", 32'(sclk), 32'd1);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_res", 32'(res), 32'd0);
    check("reset_cmplt", 32'(cnv_cmplt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", 32'(state), 32'(IDLE));
    rst = 1'b0;

    // three successive channel-0 conversions
    do_conv(3'd0, 16'hF505, 1'b0, 0);
    check_conv(16'h0000);
    do_conv(3'd0, 16'h04F5, 1'b0, 0);
    check_conv(16'h0000);
    do_conv(3'd0, 16'h04E5, 1'b0, 0);
    check_conv(16'h0000);

    // channel 3 addressing
    do_conv(3'd3, 16'h3123, 1'b0, 0);
    check_conv(16'h1800);

    // strt and chnnl toggled while busy
    do_conv(3'd5, 16'h0777, 1'b1, 0);
    check_conv(16'h2800);

    // reset during frame 2, SHIFT period 7, then no completion afterwards
    do_conv(3'd2, 16'h0123, 1'b0, 810);
    cmplt_cnt = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (cnv_cmplt) cmplt_cnt++;
    end
    check("post_rst_cmplt", 32'(cmplt_cnt), 32'd0);

    // a normal conversion after the reset
    do_conv(3'd1, 16'h0ABC, 1'b0, 0);
    check_conv(16'h0800);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    // fast SCLK instance
    do_conv4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
